// File: rtl/decoder_scan_n.sv
// N-to-2^N one-hot decoder with registered outputs and a prescaled scan mode that walks the select.
// Latency: 1 cycle from inputs to d/idx/valid/wrap; no combinational input-to-output paths.
// Backpressure: none; en=0 blanks d and freezes the scan index and prescaler in place.
module decoder_scan_n #(
    parameter int SEL_W = 3,
    parameter int DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      s,
    input  logic                  load,
    output logic [2**SEL_W-1:0]   d,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap
);
    localparam int OUT_W = 2**SEL_W;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]    presc, presc_nxt;
    logic             scanning, scanning_nxt;
    logic [SEL_W-1:0] idx_nxt;
    logic [OUT_W-1:0] d_nxt;
    logic             valid_nxt, wrap_nxt;

    always_comb begin
        presc_nxt    = presc;
        scanning_nxt = scanning;
        idx_nxt      = idx;
        valid_nxt    = 1'b0;
        wrap_nxt     = 1'b0;
        if (en) begin
            valid_nxt = 1'b1;
            if (!mode) begin
                idx_nxt      = s;
                presc_nxt    = '0;
                scanning_nxt = 1'b0;
            end else if (load) begin
                idx_nxt      = s;
                presc_nxt    = '0;
                scanning_nxt = 1'b1;
            end else if (!scanning) begin
                // First scan cycle after reset or decode: light the current index, start a full dwell.
                presc_nxt    = '0;
                scanning_nxt = 1'b1;
            end else if (presc == PRESC_LAST) begin
                idx_nxt   = idx + 1'b1;
                presc_nxt = '0;
                wrap_nxt  = (idx == {SEL_W{1'b1}});
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end
        d_nxt = '0;
        if (valid_nxt) begin
            d_nxt[idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d        <= '0;
            idx      <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
            presc    <= '0;
            scanning <= 1'b0;
        end else begin
            d        <= d_nxt;
            idx      <= idx_nxt;
            valid    <= valid_nxt;
            wrap     <= wrap_nxt;
            presc    <= presc_nxt;
            scanning <= scanning_nxt;
        end
    end
endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: three instances (3-bit/DIV=4, 3-bit/DIV=1, 4-bit/DIV=3) against a dwell-count model.
module tb_decoder_scan_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       rst_a = 1'b1, en_a = 1'b0, mode_a = 1'b0, load_a = 1'b0;
    logic [2:0] s_a = '0;
    logic [7:0] d_a;
    logic [2:0] idx_a;
    logic       valid_a, wrap_a;

    logic       rst_b = 1'b1, en_b = 1'b0, mode_b = 1'b0, load_b = 1'b0;
    logic [2:0] s_b = '0;
    logic [7:0] d_b;
    logic [2:0] idx_b;
    logic       valid_b, wrap_b;

    logic        rst_c = 1'b1, en_c = 1'b0, mode_c = 1'b0, load_c = 1'b0;
    logic [3:0]  s_c = '0;
    logic [15:0] d_c;
    logic [3:0]  idx_c;
    logic        valid_c, wrap_c;

    decoder_scan_n #(.SEL_W(3), .DIV(4)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .s(s_a), .load(load_a),
        .d(d_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a));
    decoder_scan_n #(.SEL_W(3), .DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .s(s_b), .load(load_b),
        .d(d_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b));
    decoder_scan_n #(.SEL_W(4), .DIV(3)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .mode(mode_c), .s(s_c), .load(load_c),
        .d(d_c), .idx(idx_c), .valid(valid_c), .wrap(wrap_c));

    // dwell = number of scan cycles the current index has been shown so far
    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] dwell;
        logic        in_scan;
        logic        valid;
        logic        wrap;
    } mstate_t;

    mstate_t ma = '0, mb = '0, mc = '0;

    function automatic mstate_t mstep(mstate_t m, logic rst, logic en, logic mode, logic load,
                                      int s, int nout, int div);
        mstate_t n = m;
        n.wrap = 1'b0;
        if (rst) return '0;
        if (!en) begin
            n.valid = 1'b0;
            return n;
        end
        n.valid = 1'b1;
        if (!mode) begin
            n.idx = 8'(s); n.dwell = '0; n.in_scan = 1'b0;
        end else if (load) begin
            n.idx = 8'(s); n.dwell = 16'd1; n.in_scan = 1'b1;
        end else if (!n.in_scan) begin
            n.dwell = 16'd1; n.in_scan = 1'b1;
        end else if (int'(m.dwell) == div) begin
            n.idx   = 8'((int'(m.idx) + 1) % nout);
            n.dwell = 16'd1;
            n.wrap  = (n.idx == 8'd0);
        end else begin
            n.dwell = m.dwell + 16'd1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= mstep(ma, rst_a, en_a, mode_a, load_a, int'(s_a), 8, 4);
        mb <= mstep(mb, rst_b, en_b, mode_b, load_b, int'(s_b), 8, 1);
        mc <= mstep(mc, rst_c, en_c, mode_c, load_c, int'(s_c), 16, 3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input logic [15:0] d, input int idx, input logic v,
                       input logic w, input mstate_t m);
        logic [15:0] expd;
        logic        inv_ok;
        expd   = m.valid ? (16'd1 << m.idx) : 16'd0;
        inv_ok = v ? (d == (16'd1 << idx)) : (d == 16'd0);
        chk({tag, "_d"}, 32'(d), 32'(expd));
        chk({tag, "_idx"}, 32'(idx), 32'(m.idx));
        chk({tag, "_valid"}, 32'(v), 32'(m.valid));
        chk({tag, "_wrap"}, 32'(w), 32'(m.wrap));
        chk({tag, "_inv"}, 32'(inv_ok), 32'd1);
    endtask

    always @(negedge clk) begin
        cmp("model_a", 16'(d_a), int'(idx_a), valid_a, wrap_a, ma);
        cmp("model_b", 16'(d_b), int'(idx_b), valid_b, wrap_b, mb);
        cmp("model_c", d_c, int'(idx_c), valid_c, wrap_c, mc);
    end

    int seq_b[7] = '{2, 3, 4, 5, 6, 7, 0};

    initial begin
        // Instance A: reset, decode sweep
        repeat (2) begin
            @(negedge clk);
            chk("a_rst_d", 32'(d_a), 32'h0);
            chk("a_rst_valid", 32'(valid_a), 32'h0);
        end
        rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_a = 3'(i);
            @(negedge clk);
            chk("a_dec_d", 32'(d_a), 32'd1 << i);
            chk("a_dec_idx", 32'(idx_a), 32'(i));
            if (i == 5) chk("a_dec5_d", 32'(d_a), 32'b0010_0000);
        end

        // Instance A: full scan from reset, wrap on cycle 33
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; mode_a = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            chk("a_scan_d", 32'(d_a), 32'd1 << (((c - 1) / 4) % 8));
            chk("a_scan_wrap", 32'(wrap_a), 32'(c == 33));
        end

        // Freeze at idx=3 with prescaler mid-dwell, then resume
        repeat (14) @(negedge clk);
        chk("a_pre_freeze_idx", 32'(idx_a), 32'd3);
        en_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("a_freeze_d", 32'(d_a), 32'h0);
            chk("a_freeze_valid", 32'(valid_a), 32'h0);
        end
        en_a = 1'b1;
        @(negedge clk);
        chk("a_resume_d", 32'(d_a), 32'h08);
        @(negedge clk);
        chk("a_resume_step_d", 32'(d_a), 32'h10);

        // Load on the cycle a step from idx=7 is due
        repeat (15) @(negedge clk);
        chk("a_preload_d", 32'(d_a), 32'h80);
        load_a = 1'b1; s_a = 3'd6;
        @(negedge clk);
        chk("a_load_idx", 32'(idx_a), 32'd6);
        chk("a_load_d", 32'(d_a), 32'h40);
        chk("a_load_wrap", 32'(wrap_a), 32'h0);
        load_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("a_load_dwell_d", 32'(d_a), 32'h40);
        end
        @(negedge clk);
        chk("a_load_step_idx", 32'(idx_a), 32'd7);
        chk("a_load_step_d", 32'(d_a), 32'h80);
        en_a = 1'b0;

        // Instance B (DIV=1): decode 2, scan, decode 1
        rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b0; s_b = 3'd2;
        @(negedge clk);
        chk("b_dec_idx", 32'(idx_b), 32'd2);
        mode_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("b_scan_idx", 32'(idx_b), 32'(seq_b[k]));
            chk("b_scan_wrap", 32'(wrap_b), 32'(k == 6));
        end
        mode_b = 1'b0; s_b = 3'd1;
        @(negedge clk);
        chk("b_back_dec_d", 32'(d_b), 32'h02);
        en_b = 1'b0;

        // Instance C (SEL_W=4, DIV=3): reset mid-scan at idx=9
        rst_c = 1'b0; en_c = 1'b1; mode_c = 1'b1;
        repeat (28) @(negedge clk);
        chk("c_pre_rst_idx", 32'(idx_c), 32'd9);
        chk("c_pre_rst_d", 32'(d_c), 32'h0200);
        rst_c = 1'b1;
        @(negedge clk);
        chk("c_rst_d", 32'(d_c), 32'h0);
        chk("c_rst_idx", 32'(idx_c), 32'h0);
        chk("c_rst_valid", 32'(valid_c), 32'h0);
        rst_c = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("c_post_rst_d", 32'(d_c), 32'h0001);
        end
        @(negedge clk);
        chk("c_first_step_d", 32'(d_c), 32'h0002);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
